wall_map_arbiter: RTL and testbench



---
 rtl/wall_map_arbiter.sv | 170 +++++++++++++++++
 tb/tb_wall_map_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wall_map_arbiter.sv
// wall_map_arbiter
// Shares one single-port synchronous wall-map RAM between the VGA wall
// lookup and three game requesters (tank0, tank1, shell engine).
//
// The VGA path has absolute priority, but it only uses the RAM when its
// requested cell differs from the cached one (or the cache is invalid).
// Every other cycle is handed out round-robin to the game requesters.
// Requester 2 (shell engine) may also write, which is how walls get cleared.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_vga_x/i_vga_y    VGA requested cell
//   o_vga_is_wall      wall bit for the last VGA-requested cell
//   i_req              per-requester level request, held until granted
//   i_req_x/i_req_y    packed cell coordinates, 6 bits per requester
//   i_we/i_wdata       requester 2 write strobe and data
//   o_gnt              one-hot combinational grant
//   o_rvalid/o_rdata   registered read return, one cycle after grant
//   o_mem_*            RAM control/address/write data
//   i_mem_data         RAM read data, one cycle after a read enable
module wall_map_arbiter #(
  parameter int MAP_W = 64,
  parameter int MAP_H = 44,
  parameter int N_REQ = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  i_vga_x,
  input  logic [5:0]  i_vga_y,
  output logic        o_vga_is_wall,
  input  logic [2:0]  i_req,
  input  logic [17:0] i_req_x,
  input  logic [17:0] i_req_y,
  input  logic        i_we,
  input  logic        i_wdata,
  output logic [2:0]  o_gnt,
  output logic [2:0]  o_rvalid,
  output logic        o_rdata,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [11:0] o_mem_addr,
  output logic        o_mem_wdata,
  input  logic        i_mem_data
);

  // FILL: cached VGA address not trusted; RUN: cache holds the RAM contents.
  typedef enum logic {FILL, RUN} state_t;

  state_t      state_p0, state_nxt;
  logic [11:0] cache_addr_p0;
  logic [1:0]  ptr_p0;
  logic        vga_pending_p1;
  logic        hold_p1;
  logic [2:0]  rvalid_p1;
  logic        oor_p1;

  logic [11:0] vga_addr;
  logic        vga_slot;
  logic [2:0]  gnt;
  logic [1:0]  gnt_idx;
  logic        gnt_any;
  logic [5:0]  sel_x, sel_y;
  logic        in_range;
  logic        is_wr;
  logic        wr_hit;
  logic [1:0]  ptr_nxt;

  assign vga_addr = {i_vga_y, i_vga_x};
  assign vga_slot = (state_p0 == FILL) || (vga_addr != cache_addr_p0);

  // ---- stage p0: slot decision and round-robin arbitration ----
  always_comb begin : arb
    int j;
    logic [1:0] idx;
    gnt     = '0;
    gnt_idx = ptr_p0;
    gnt_any = 1'b0;
    j       = 0;
    idx     = 2'd0;
    if (!vga_slot) begin
      for (int i = 0; i < N_REQ; i++) begin
        j = int'(ptr_p0) + i;
        if (j >= N_REQ) j = j - N_REQ;
        idx = 2'(j);
        if (!gnt_any && i_req[idx]) begin
          gnt_any  = 1'b1;
          gnt_idx  = idx;
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (gnt_idx)
      2'd1:    begin sel_x = i_req_x[11:6];  sel_y = i_req_y[11:6];  end
      2'd2:    begin sel_x = i_req_x[17:12]; sel_y = i_req_y[17:12]; end
      default: begin sel_x = i_req_x[5:0];   sel_y = i_req_y[5:0];   end
    endcase
  end

  assign in_range = (int'(sel_x) < MAP_W) && (int'(sel_y) < MAP_H);
  assign is_wr    = gnt_any && (gnt_idx == 2'd2) && i_we;
  // A landed write onto the cell VGA is showing must force a re-read.
  assign wr_hit   = is_wr && in_range && ({sel_y, sel_x} == cache_addr_p0);
  assign ptr_nxt  = (gnt_idx >= 2'(N_REQ - 1)) ? 2'd0 : gnt_idx + 2'd1;

  // Cache state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p0 <= FILL;
    else        state_p0 <= state_nxt;
  end

  // Cache next-state logic
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      FILL:    if (vga_slot) state_nxt = RUN;
      RUN:     if (wr_hit)   state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // RAM port and grant outputs
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = vga_addr;
    o_mem_wdata = 1'b0;
    if (vga_slot) begin
      o_mem_en = 1'b1;
    end else if (gnt_any && in_range) begin
      o_mem_en   = 1'b1;
      o_mem_addr = {sel_y, sel_x};
      if (is_wr) begin
        o_mem_we    = 1'b1;
        o_mem_wdata = i_wdata;
      end
    end
  end

  assign o_gnt = gnt;

  // ---- stage p1: RAM data return ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_addr_p0  <= '0;
      ptr_p0         <= '0;
      vga_pending_p1 <= 1'b0;
      hold_p1        <= 1'b0;
      rvalid_p1      <= '0;
    end else begin
      vga_pending_p1 <= vga_slot;
      if (vga_slot)       cache_addr_p0 <= vga_addr;
      if (vga_pending_p1) hold_p1       <= i_mem_data;
      if (gnt_any)        ptr_p0        <= ptr_nxt;
      rvalid_p1 <= (gnt_any && !is_wr) ? gnt : 3'b000;
    end
  end

  // Out-of-range reads return "wall"; only meaningful when rvalid_p1 is set.
  always_ff @(posedge clk) begin
    oor_p1 <= !in_range;
  end

  assign o_rvalid      = rvalid_p1;
  assign o_rdata       = oor_p1 ? 1'b1 : i_mem_data;
  assign o_vga_is_wall = vga_pending_p1 ? i_mem_data : hold_p1;

endmodule

// File: tb/tb_wall_map_arbiter.sv
// Testbench for wall_map_arbiter: behavioural RAM, read-return scoreboard,
// and one task per scenario.
module tb_wall_map_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  vga_x, vga_y;
  logic        vga_is_wall;
  logic [2:0]  req;
  logic [17:0] req_x, req_y;
  logic        we, wdata;
  logic [2:0]  gnt, rvalid;
  logic        rdata;
  logic        mem_en, mem_we, mem_wdata, mem_data;
  logic [11:0] mem_addr;

  bit          ram [4096];
  logic        bk_we;
  logic [11:0] bk_addr;
  logic        bk_data;

  typedef struct {
    int   k;
    logic d;
  } exp_t;
  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wall_map_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_vga_x      (vga_x),
    .i_vga_y      (vga_y),
    .o_vga_is_wall(vga_is_wall),
    .i_req        (req),
    .i_req_x      (req_x),
    .i_req_y      (req_y),
    .i_we         (we),
    .i_wdata      (wdata),
    .o_gnt        (gnt),
    .o_rvalid     (rvalid),
    .o_rdata      (rdata),
    .o_mem_en     (mem_en),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_data   (mem_data)
  );

  // Single-port synchronous RAM with a bench backdoor for preloading.
  always @(posedge clk) begin
    if (bk_we) ram[bk_addr] <= bk_data;
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_data      <= ram[mem_addr];
    end
  end

  // Scoreboard: every read return is popped and compared.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1 && rvalid !== 3'b000) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected got rvalid=%b rdata=%b", rvalid, rdata);
      end else begin
        e = sbq.pop_front();
        if (rvalid !== (3'b001 << e.k) || rdata !== e.d) begin
          errors++;
          $display("FAIL rvalid_data got rvalid=%b rdata=%b expected rvalid=%b rdata=%b",
                   rvalid, rdata, 3'b001 << e.k, e.d);
        end
      end
    end
  end

  function automatic logic [11:0] ca(input int x, input int y);
    return {6'(y), 6'(x)};
  endfunction

  task automatic bk(input logic [11:0] a, input logic d);
    @(negedge clk);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    @(negedge clk);
    bk_we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = '0; req_x = '0; req_y = '0; we = 1'b0; wdata = 1'b0;
    vga_x = 6'd5; vga_y = 6'd3; bk_we = 1'b0; bk_addr = '0; bk_data = 1'b0;
    repeat (2) @(negedge clk);
    bk(ca(5, 3), 1'b1);
    bk(ca(1, 2), 1'b1);
    bk(ca(7, 8), 1'b1);
    bk(ca(6, 3), 1'b1);
    bk(ca(10, 20), 1'b1);
    @(negedge clk); #1;
    checks++;
    if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid got=%b exp=000", rvalid); end
    checks++;
    if (vga_is_wall !== 1'b0) begin errors++; $display("FAIL reset_wall got=%b exp=0", vga_is_wall); end
  endtask

  task automatic test_vga_read;
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 12'h0C5 || gnt !== 3'b000) begin
      errors++;
      $display("FAIL vga_first_slot got en=%b addr=%h gnt=%b exp en=1 addr=0c5 gnt=000", mem_en, mem_addr, gnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (vga_is_wall !== 1'b1 || mem_en !== 1'b0) begin
        errors++;
        $display("FAIL vga_hold cyc=%0d got wall=%b en=%b exp wall=1 en=0", i, vga_is_wall, mem_en);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] eg [4];
    int kk;
    eg[0] = 3'b001; eg[1] = 3'b010; eg[2] = 3'b100; eg[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req   = 3'b111;
        req_x = {6'd7, 6'd3, 6'd1};
        req_y = {6'd8, 6'd4, 6'd2};
      end
      #1;
      kk = (i == 3) ? 0 : i;
      checks++;
      if (gnt !== eg[i] || mem_en !== 1'b1 || mem_we !== 1'b0 ||
          mem_addr !== {req_y[6*kk +: 6], req_x[6*kk +: 6]}) begin
        errors++;
        $display("FAIL rr_grant cyc=%0d got gnt=%b addr=%h en=%b exp gnt=%b addr=%h en=1",
                 i, gnt, mem_addr, mem_en, eg[i], {req_y[6*kk +: 6], req_x[6*kk +: 6]});
      end
      sbq.push_back('{kk, ram[{req_y[6*kk +: 6], req_x[6*kk +: 6]}]});
    end
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_vga_priority;
    @(negedge clk);
    vga_x = 6'd6; vga_y = 6'd3; req = 3'b001; req_x[5:0] = 6'd9; req_y[5:0] = 6'd9;
    #1;
    checks++;
    if (gnt !== 3'b000 || mem_en !== 1'b1 || mem_addr !== ca(6, 3)) begin
      errors++;
      $display("FAIL vga_priority got gnt=%b en=%b addr=%h exp gnt=000 en=1 addr=%h", gnt, mem_en, mem_addr, ca(6, 3));
    end
    @(negedge clk); #1;
    checks++;
    if (gnt !== 3'b001 || mem_addr !== ca(9, 9)) begin
      errors++;
      $display("FAIL deferred_grant got gnt=%b addr=%h exp gnt=001 addr=%h", gnt, mem_addr, ca(9, 9));
    end
    checks++;
    if (vga_is_wall !== ram[ca(6, 3)]) begin
      errors++;
      $display("FAIL vga_change_wall got=%b exp=%b", vga_is_wall, ram[ca(6, 3)]);
    end
    sbq.push_back('{0, ram[ca(9, 9)]});
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_out_of_range;
    @(negedge clk);
    req = 3'b010; req_x[11:6] = 6'd5; req_y[11:6] = 6'd44;
    #1;
    checks++;
    if (gnt !== 3'b010 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL oor_read got gnt=%b en=%b exp gnt=010 en=0", gnt, mem_en);
    end
    sbq.push_back('{1, 1'b1});
    @(negedge clk);
    req = 3'b100; we = 1'b1; wdata = 1'b0; req_x[17:12] = 6'd3; req_y[17:12] = 6'd50;
    #1;
    checks++;
    if (gnt !== 3'b100 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL oor_write got gnt=%b en=%b exp gnt=100 en=0", gnt, mem_en);
    end
    @(negedge clk);
    req = '0; we = 1'b0;
  endtask

  task automatic test_write_invalidate;
    @(negedge clk);
    vga_x = 6'd10; vga_y = 6'd20;
    #1;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== ca(10, 20)) begin
      errors++;
      $display("FAIL wi_vga_slot got en=%b addr=%h exp en=1 addr=%h", mem_en, mem_addr, ca(10, 20));
    end
    @(negedge clk); #1;
    checks++;
    if (vga_is_wall !== 1'b1) begin errors++; $display("FAIL wi_wall_before got=%b exp=1", vga_is_wall); end
    @(negedge clk);
    req = 3'b100; we = 1'b1; wdata = 1'b0; req_x[17:12] = 6'd10; req_y[17:12] = 6'd20;
    #1;
    checks++;
    if (gnt !== 3'b100 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
        mem_addr !== ca(10, 20) || mem_wdata !== 1'b0) begin
      errors++;
      $display("FAIL wi_write got gnt=%b en=%b we=%b addr=%h wd=%b exp gnt=100 en=1 we=1 addr=%h wd=0",
               gnt, mem_en, mem_we, mem_addr, mem_wdata, ca(10, 20));
    end
    @(negedge clk);
    req = '0; we = 1'b0;
    #1;
    checks++;
    if (gnt !== 3'b000 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ca(10, 20)) begin
      errors++;
      $display("FAIL wi_reread got gnt=%b en=%b we=%b addr=%h exp gnt=000 en=1 we=0 addr=%h",
               gnt, mem_en, mem_we, mem_addr, ca(10, 20));
    end
    @(negedge clk); #1;
    checks++;
    if (vga_is_wall !== 1'b0) begin errors++; $display("FAIL wi_wall_after got=%b exp=0", vga_is_wall); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req = 3'b001; req_x[5:0] = 6'd7; req_y[5:0] = 6'd8;
    #1;
    checks++;
    if (gnt !== 3'b001 || mem_addr !== ca(7, 8)) begin
      errors++;
      $display("FAIL b2b_first got gnt=%b addr=%h exp gnt=001 addr=%h", gnt, mem_addr, ca(7, 8));
    end
    sbq.push_back('{0, ram[ca(7, 8)]});
    @(negedge clk);
    req_x[5:0] = 6'd3; req_y[5:0] = 6'd4;
    #1;
    checks++;
    if (gnt !== 3'b001 || mem_addr !== ca(3, 4)) begin
      errors++;
      $display("FAIL b2b_second got gnt=%b addr=%h exp gnt=001 addr=%h", gnt, mem_addr, ca(3, 4));
    end
    sbq.push_back('{0, ram[ca(3, 4)]});
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    req = 3'b010; req_x[11:6] = 6'd1; req_y[11:6] = 6'd2;
    #1;
    checks++;
    if (gnt !== 3'b010) begin errors++; $display("FAIL rst_pre_grant got=%b exp=010", gnt); end
    #2;
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (rvalid !== 3'b000 || vga_is_wall !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard got rvalid=%b wall=%b exp rvalid=000 wall=0", rvalid, vga_is_wall);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (gnt !== 3'b000 || mem_en !== 1'b1 || mem_addr !== ca(10, 20)) begin
      errors++;
      $display("FAIL rst_fill got gnt=%b en=%b addr=%h exp gnt=000 en=1 addr=%h", gnt, mem_en, mem_addr, ca(10, 20));
    end
    @(negedge clk);
    req = 3'b111; req_x[5:0] = 6'd1; req_y[5:0] = 6'd2;
    #1;
    checks++;
    if (gnt !== 3'b001 || vga_is_wall !== 1'b0) begin
      errors++;
      $display("FAIL rst_ptr got gnt=%b wall=%b exp gnt=001 wall=0", gnt, vga_is_wall);
    end
    sbq.push_back('{0, ram[ca(1, 2)]});
    @(negedge clk);
    req = '0;
  endtask

  initial begin
    test_reset();
    test_vga_read();
    test_round_robin();
    test_vga_priority();
    test_out_of_range();
    test_write_invalidate();
    test_back_to_back();
    test_reset_midop();
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL missing_rvalid got outstanding=%0d exp=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
